// File: rtl/text_cursor_writer_if.sv
// Byte-stream input and character-plane write bus of the text cursor writer.
// The master side feeds bytes and observes the writes; the slave side is the writer.
interface text_cursor_writer_if #(
  parameter int ROW_BIT_LEN    = 4,
  parameter int COL_BIT_LEN    = 5,
  parameter int CHAR_ID_LENGTH = 8
);
  logic [7:0]                in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic                      wr_en;
  logic [ROW_BIT_LEN-1:0]    wr_row;
  logic [COL_BIT_LEN-1:0]    wr_col;
  logic [CHAR_ID_LENGTH-1:0] wr_char;
  logic [ROW_BIT_LEN-1:0]    cursor_row;
  logic [COL_BIT_LEN-1:0]    cursor_col;
  logic                      busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_row, wr_col, wr_char, cursor_row, cursor_col, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_row, wr_col, wr_char, cursor_row, cursor_col, busy
  );
endinterface

// File: rtl/text_cursor_writer.sv
// Turns a valid/ready byte stream into single-cell character writes, tracking a
// text cursor and handling CR, LF, BS and FF with row and full-screen clears.
module text_cursor_writer #(
  parameter int                        ROW_NUMBER     = 16,
  parameter int                        COL_NUMBER     = 32,
  parameter int                        ROW_BIT_LEN    = 4,
  parameter int                        COL_BIT_LEN    = 5,
  parameter int                        CHAR_ID_LENGTH = 8,
  parameter logic [CHAR_ID_LENGTH-1:0] BLANK_CHAR     = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  text_cursor_writer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR_ROW, CLEAR_ALL} state_t;

  localparam logic [ROW_BIT_LEN-1:0] LAST_ROW      = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0] LAST_COL      = COL_BIT_LEN'(COL_NUMBER - 1);
  localparam logic [COL_BIT_LEN:0]   ROW_CNT_LAST  = (COL_BIT_LEN+1)'(COL_NUMBER - 1);

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

  state_t                            state;
  logic [7:0]                        byte_q;
  logic [COL_BIT_LEN:0]              row_cnt;
  logic [ROW_BIT_LEN+COL_BIT_LEN-1:0] all_cnt;

  logic [ROW_BIT_LEN-1:0] all_row;
  logic [COL_BIT_LEN-1:0] all_col;
  logic [ROW_BIT_LEN-1:0] next_row;
  logic                   printable;

  // The clear-all counter is {row, col}; a column wrap jumps straight to the next row field.
  assign all_row   = all_cnt[COL_BIT_LEN +: ROW_BIT_LEN];
  assign all_col   = all_cnt[COL_BIT_LEN-1:0];
  assign next_row  = (bus.cursor_row == LAST_ROW) ? '0
                                                  : bus.cursor_row + ROW_BIT_LEN'(1);
  assign printable = (byte_q >= 8'h20) && (byte_q <= 8'h7E);

  // NOTE: every register here is updated with <= so all branches see pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= CLEAR_ALL;
      byte_q         <= '0;
      row_cnt        <= '0;
      all_cnt        <= '0;
      bus.in_ready   <= 1'b0;
      bus.busy       <= 1'b1;
      bus.wr_en      <= 1'b0;
      bus.wr_row     <= '0;
      bus.wr_col     <= '0;
      bus.wr_char    <= BLANK_CHAR;
      bus.cursor_row <= '0;
      bus.cursor_col <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        IDLE: begin
          // in_ready rises one cycle after the state returns to IDLE.
          if (!bus.in_ready) begin
            bus.in_ready <= 1'b1;
          end else if (bus.in_valid) begin
            byte_q       <= bus.in_data;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= EXEC;
          end
        end

        EXEC: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          if (printable) begin
            bus.wr_en   <= 1'b1;
            bus.wr_row  <= bus.cursor_row;
            bus.wr_col  <= bus.cursor_col;
            bus.wr_char <= CHAR_ID_LENGTH'(byte_q);
            if (bus.cursor_col == LAST_COL) begin
              bus.cursor_col <= '0;
              bus.cursor_row <= next_row;
              row_cnt        <= '0;
              bus.busy       <= 1'b1;
              state          <= CLEAR_ROW;
            end else begin
              bus.cursor_col <= bus.cursor_col + COL_BIT_LEN'(1);
            end
          end else begin
            case (byte_q)
              CODE_CR: bus.cursor_col <= '0;
              CODE_LF: begin
                bus.cursor_col <= '0;
                bus.cursor_row <= next_row;
                row_cnt        <= '0;
                bus.busy       <= 1'b1;
                state          <= CLEAR_ROW;
              end
              CODE_BS: begin
                if (bus.cursor_col != '0) begin
                  bus.wr_en      <= 1'b1;
                  bus.wr_row     <= bus.cursor_row;
                  bus.wr_col     <= bus.cursor_col - COL_BIT_LEN'(1);
                  bus.wr_char    <= BLANK_CHAR;
                  bus.cursor_col <= bus.cursor_col - COL_BIT_LEN'(1);
                end
              end
              CODE_FF: begin
                bus.cursor_row <= '0;
                bus.cursor_col <= '0;
                all_cnt        <= '0;
                bus.busy       <= 1'b1;
                state          <= CLEAR_ALL;
              end
              default: ;
            endcase
          end
        end

        CLEAR_ROW: begin
          bus.wr_en   <= 1'b1;
          bus.wr_row  <= bus.cursor_row;
          bus.wr_col  <= row_cnt[COL_BIT_LEN-1:0];
          bus.wr_char <= BLANK_CHAR;
          if (row_cnt == ROW_CNT_LAST) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            row_cnt <= row_cnt + (COL_BIT_LEN+1)'(1);
          end
        end

        CLEAR_ALL: begin
          bus.wr_en   <= 1'b1;
          bus.wr_row  <= all_row;
          bus.wr_col  <= all_col;
          bus.wr_char <= BLANK_CHAR;
          if (all_row == LAST_ROW && all_col == LAST_COL) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (all_col == LAST_COL) begin
            all_cnt <= {all_row + ROW_BIT_LEN'(1), COL_BIT_LEN'(0)};
          end else begin
            all_cnt <= all_cnt + (ROW_BIT_LEN+COL_BIT_LEN)'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_cursor_writer.sv
// Randomized and directed bench for text_cursor_writer; every write, latency and
// cursor position is compared against a screen-level model of the byte semantics.
module tb_text_cursor_writer;

  localparam int ROWS = 16;
  localparam int COLS = 32;
  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [31:0] NO_WRITE_EXPECTED = 32'hDEAD_BEEF;

  logic clk;
  logic reset_n;

  text_cursor_writer_if #(.ROW_BIT_LEN(4), .COL_BIT_LEN(5), .CHAR_ID_LENGTH(8)) bus ();

  text_cursor_writer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          m_row;
  int          m_col;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic logic [31:0] wword(input int r, input int c, input logic [7:0] ch);
    logic [3:0] r4;
    logic [4:0] c5;
    r4 = r[3:0];
    c5 = c[4:0];
    return {15'd0, r4, c5, ch};
  endfunction

  function automatic void push_row_clear(input int r);
    for (int c = 0; c < COLS; c++) exp_q.push_back(wword(r, c, BLANK));
  endfunction

  function automatic void push_screen_clear();
    for (int r = 0; r < ROWS; r++) push_row_clear(r);
  endfunction

  function automatic void reset_model();
    m_row = 0;
    m_col = 0;
    exp_q.delete();
    push_screen_clear();
  endfunction

  // Byte semantics; ready_k is the negedge index (after the handshake edge) at which
  // in_ready is first seen high again, wr_k the index of the first write (0 = unchecked).
  function automatic void apply_byte(input logic [7:0] b, output int ready_k, output int wr_k);
    ready_k = 3;
    wr_k    = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back(wword(m_row, m_col, b));
      wr_k = 2;
      if (m_col < COLS - 1) begin
        m_col++;
      end else begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        push_row_clear(m_row);
        ready_k = 3 + COLS;
      end
    end else begin
      case (b)
        8'h0D: m_col = 0;
        8'h0A: begin
          m_col = 0;
          m_row = (m_row + 1) % ROWS;
          push_row_clear(m_row);
          ready_k = 3 + COLS;
        end
        8'h08: begin
          if (m_col > 0) begin
            m_col--;
            exp_q.push_back(wword(m_row, m_col, BLANK));
            wr_k = 2;
          end
        end
        8'h0C: begin
          m_row = 0;
          m_col = 0;
          push_screen_clear();
          ready_k = 3 + ROWS * COLS;
        end
        default: ;
      endcase
    end
  endfunction

  // Every observed write must be the next one the model predicts.
  always @(negedge clk) begin
    if (reset_n && bus.wr_en) begin
      logic [31:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : NO_WRITE_EXPECTED;
      check("write", wword(int'(bus.wr_row), int'(bus.wr_col), bus.wr_char), e);
    end
  end

  task automatic check_reset_vals();
    check("rst_wr_en",    32'(bus.wr_en),      32'd0);
    check("rst_wr_row",   32'(bus.wr_row),     32'd0);
    check("rst_wr_col",   32'(bus.wr_col),     32'd0);
    check("rst_wr_char",  32'(bus.wr_char),    32'(BLANK));
    check("rst_cursor",   32'({bus.cursor_row, bus.cursor_col}), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready),   32'd0);
    check("rst_busy",     32'(bus.busy),       32'd1);
  endtask

  // Waits (bounded) at negedges for in_ready; toggles or holds in_valid while it is low.
  task automatic wait_ready(input int limit, input bit hold, input logic [7:0] hold_data,
                            output int k_high, output int wr_k);
    k_high = 0;
    wr_k   = 0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (bus.wr_en && wr_k == 0) wr_k = k;
      if (bus.in_ready) begin
        k_high = k;
        if (!hold) bus.in_valid = 1'b0;
        break;
      end
      if (hold) begin
        bus.in_valid = 1'b1;
        bus.in_data  = hold_data;
      end else begin
        bus.in_valid = 1'($urandom);
        bus.in_data  = 8'($urandom);
      end
    end
    if (k_high == 0) begin
      check("ready_timeout", 32'(k_high), 32'(limit));
      finish_sim();
    end
  endtask

  task automatic check_cursor(input string tag);
    check(tag, 32'({bus.cursor_row, bus.cursor_col}), 32'({m_row[3:0], m_col[4:0]}));
  endtask

  // Caller guarantees in_ready was seen high at the current negedge.
  task automatic send_byte(input logic [7:0] b, input bit hold = 1'b0, input logic [7:0] nxt = 8'h00);
    int exp_k, exp_wr, k, wr;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    apply_byte(b, exp_k, exp_wr);
    #1;
    if (hold) begin
      bus.in_data = nxt;
    end else begin
      bus.in_valid = 1'($urandom);
      bus.in_data  = 8'($urandom);
    end
    wait_ready(exp_k + 20, hold, nxt, k, wr);
    check("ready_latency", 32'(k), 32'(exp_k));
    if (exp_wr != 0) check("write_latency", 32'(wr), 32'(exp_wr));
    check_cursor("cursor");
    check("busy_when_ready", 32'(bus.busy), 32'd0);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_release_and_clear();
    int k, wr;
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready(ROWS * COLS + 40, 1'b0, 8'h00, k, wr);
    check("clear_all_ready_k", 32'(k), 32'(ROWS * COLS + 1));
    check("clear_all_first_wr", 32'(wr), 32'd1);
    check("clear_all_drained", 32'(exp_q.size()), 32'd0);
    check("post_clear_cursor", 32'({bus.cursor_row, bus.cursor_col}), 32'd0);
  endtask

  task automatic move_to(input int r, input int c);
    send_byte(8'h0C);
    for (int i = 0; i < r; i++) send_byte(8'h0A);
    for (int i = 0; i < c; i++) send_byte(8'h61 + 8'(i % 26));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] b;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset_model();
    #12;
    check_reset_vals();
    reset_release_and_clear();

    // Back-to-back "AB" with in_valid held high between the two bytes.
    send_byte(8'h41, 1'b1, 8'h42);
    send_byte(8'h42);
    check("ab_cursor", 32'({bus.cursor_row, bus.cursor_col}), 32'({4'd0, 5'd2}));

    // A full line of printable bytes wraps into row 1 and clears it.
    send_byte(8'h0C);
    for (int i = 0; i < COLS; i++) send_byte(8'h30 + 8'(i % 40));
    check("wrap_cursor", 32'({bus.cursor_row, bus.cursor_col}), 32'({4'd1, 5'd0}));

    // LF from the last row wraps to row 0.
    move_to(15, 5);
    send_byte(8'h0A);
    check("lf_wrap_cursor", 32'({bus.cursor_row, bus.cursor_col}), 32'd0);

    move_to(3, 7);
    send_byte(8'h0D);
    check("cr_cursor", 32'({bus.cursor_row, bus.cursor_col}), 32'({4'd3, 5'd0}));

    // Backspace mid-line, backspace at column 0, and an ignored control code.
    move_to(2, 4);
    send_byte(8'h08);
    check("bs_cursor", 32'({bus.cursor_row, bus.cursor_col}), 32'({4'd2, 5'd3}));
    send_byte(8'h0D);
    send_byte(8'h08);
    check("bs_col0_cursor", 32'({bus.cursor_row, bus.cursor_col}), 32'({4'd2, 5'd0}));
    send_byte(8'h07);

    // Reset in the middle of a form-feed clear.
    move_to(5, 9);
    bus.in_data  = 8'h0C;
    bus.in_valid = 1'b1;
    @(posedge clk);
    begin
      int ek, ew;
      apply_byte(8'h0C, ek, ew);
    end
    #1 bus.in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 300 && n < 100; i++) begin
      @(negedge clk);
      if (bus.wr_en) n++;
    end
    check("ff_writes_before_reset", 32'(n), 32'd100);
    #1 reset_n = 1'b0;
    #1 check_reset_vals();
    reset_model();
    repeat (3) @(negedge clk);
    reset_release_and_clear();

    // Randomized byte mix.
    for (int i = 0; i < 200; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 60)      b = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 70) b = 8'h0D;
      else if (r < 80) b = 8'h0A;
      else if (r < 90) b = 8'h08;
      else if (r < 92) b = 8'h0C;
      else begin
        do b = 8'($urandom_range(0, 255));
        while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0A ||
               b == 8'h0C || b == 8'h0D);
      end
      send_byte(b);
    end

    finish_sim();
  end

endmodule

// File: doc/text_cursor_writer.md
Name: text_cursor_writer

Overview:
- Upstream feeder for the character plane: consumes a byte stream (valid/ready) and turns it into single-cell writes of character ids into the ROW_NUMBER x COL_NUMBER text buffer.
- Tracks a text cursor and handles the control codes CR, LF, BS and FF.
- Clears rows on line advance and clears the whole screen on FF and after reset.
- The cursor position is exported so the pixel encoder can render a cursor.

Parameters:
ROW_NUMBER, 16, text lines in the buffer
COL_NUMBER, 32, characters per line
ROW_BIT_LEN, 4, row index width (ceil log2 ROW_NUMBER)
COL_BIT_LEN, 5, column index width (ceil log2 COL_NUMBER)
CHAR_ID_LENGTH, 8, character id width
BLANK_CHAR, 8'h20, id written when clearing cells

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
in_data  input  8  incoming byte
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a byte this cycle
wr_en  output  1  one-cycle write strobe to the character plane
wr_row  output  ROW_BIT_LEN  write row
wr_col  output  COL_BIT_LEN  write column
wr_char  output  CHAR_ID_LENGTH  character id to write
cursor_row  output  ROW_BIT_LEN  current cursor row
cursor_col  output  COL_BIT_LEN  current cursor column
busy  output  1  high in any state other than IDLE

Behaviour:
- One clock (clk); reset is asynchronous and active-low (reset_n). All outputs are registered.
- Reset values:
  - wr_en=0, wr_row=0, wr_col=0, wr_char=BLANK_CHAR.
  - cursor=(0,0), in_ready=0, busy=1.
  - State=CLEAR_ALL with clear counter 0, so a full-screen clear starts on the first edge after reset_n rises.
- Reset asserted mid-operation aborts everything immediately; the clear restarts from cell (0,0) after release.
- States:
  - IDLE: in_ready=1. Transfer occurs when in_valid && in_ready at a rising edge; the byte is latched and the state goes to EXEC. in_ready drops in the next cycle.
  - EXEC: one cycle; decodes the latched byte.
    - Printable 0x20..0x7E: write at cursor (wr_en=1, wr_row/wr_col=cursor, wr_char=byte), then advance the column.
      - Column < COL_NUMBER-1: col+1, go to IDLE.
      - Column = COL_NUMBER-1: col=0, row=(row+1) mod ROW_NUMBER, go to CLEAR_ROW.
    - 0x0D CR: col=0, no write, go to IDLE.
    - 0x0A LF: col=0, row=(row+1) mod ROW_NUMBER, go to CLEAR_ROW.
    - 0x08 BS: if col>0, write BLANK_CHAR at (row,col-1) and set col=col-1. If col=0, no write and no move. Go to IDLE.
    - 0x0C FF: cursor=(0,0), go to CLEAR_ALL.
    - Any other code: ignored, no write, go to IDLE.
  - CLEAR_ROW: writes BLANK_CHAR to cells (new row, 0..COL_NUMBER-1) on consecutive cycles, one per cycle, ascending column, wr_en held high. Then goes to IDLE. Row wrap from ROW_NUMBER-1 to 0 clears row 0 (no scrolling).
  - CLEAR_ALL: writes BLANK_CHAR to all ROW_NUMBER*COL_NUMBER cells, row-major from (0,0), one per cycle, wr_en held high. Then goes to IDLE with cursor (0,0).
- Write timing:
  - Byte accepted at edge N: its EXEC write strobe is high in the cycle after edge N+1.
  - in_ready returns high the cycle after the last write of that byte's operation.
  - Printable-with-wrap and LF therefore cost 2+COL_NUMBER cycles of in_ready low.
- wr_en is 0 in every cycle without a write. wr_row/wr_col/wr_char hold their last values when wr_en=0.
- in_valid may toggle freely while in_ready=0. No byte is lost or duplicated; exactly one byte is consumed per handshake.
- cursor_row/cursor_col update on the same edge that issues the corresponding write.
- Counter widths:
  - Clear-all counter is ROW_BIT_LEN+COL_BIT_LEN bits, so the row/col split is direct.
  - The row-clear counter is COL_BIT_LEN+1 bits wide to detect terminal count at COL_NUMBER-1 without overflow for non-power-of-two values.

Test Plan:
- Release reset -> exactly 512 consecutive wr_en cycles covering (0,0)..(15,31) in row-major order with wr_char=0x20. in_ready rises the following cycle with cursor (0,0).
- Send "AB" (0x41,0x42) back-to-back with in_valid held -> writes (0,0)=0x41 and (0,1)=0x42; cursor ends at (0,2); each write comes 2 edges after its handshake.
- Send 32 printable bytes from (0,0) -> writes (0,0)..(0,31), then 32 blank writes to row 1. Cursor ends at (1,0); in_ready stays low during the clear.
- Cursor at (15,5), send 0x0A -> cursor (0,0) and row 0 cleared (32 writes). Send 0x0D at (3,7) -> cursor (3,0) with no writes.
- Cursor (2,4), send 0x08 -> write 0x20 at (2,3), cursor (2,3). At (2,0), 0x08 -> no write, cursor unchanged. Send 0x07 -> no write, in_ready back after 2 cycles.
- Send 0x0C at (5,9), then assert reset_n=0 after 100 clear cycles -> all outputs return to reset values at once. After release, a full 512-cell clear restarts from (0,0).
